msip_chk: RTL and testbench

- Receive-side checker for the multispeed inner-product (MSIP) pseudo-random bit stream.
- Regenerates the sequence locally with two 32-bit LFSRs: a slow one advanced once every DIV input bits and a fast one advanced on every input bit.
- Compares each received bit against the expected bit, which is the parity of the bitwise AND of the two LFSRs.
- Reports lock status, per-bit error pulses and a saturating error count. Sits at the far end of a link or loopback, fed by the generator output.

---
 rtl/msip_chk.sv | 131 +++++++++++++
 tb/tb_msip_chk.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/msip_chk.sv
// Receive-side MSIP checker: regenerates the slow/fast LFSR inner-product stream,
// compares it bit by bit and reports lock, loss of lock and a saturating error count.
module msip_chk #(
    parameter int unsigned DIV      = 10,
    parameter int unsigned LOCK_CNT = 64,
    parameter int unsigned WIN      = 256,
    parameter int unsigned ERR_THR  = 8,
    parameter logic [31:0] SEED1    = 32'hACE10001,
    parameter logic [31:0] SEED2    = 32'h12345678
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_din,
    input  logic        i_din_valid,
    output logic        o_err,
    output logic        o_locked,
    output logic        o_lost,
    output logic [15:0] o_err_cnt,
    output logic [1:0]  o_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_CHECK  = 2'b01,
        ST_LOCKED = 2'b10,
        ST_LOST   = 2'b11
    } state_t;

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int WIN_W  = $clog2(WIN + 1);
    localparam int WERR_W = $clog2(ERR_THR + 1);

    localparam logic [15:0]       DIV_LAST = 16'(DIV - 1);
    localparam logic [RUN_W-1:0]  RUN_LOCK = RUN_W'(LOCK_CNT);
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WIN - 1);
    localparam logic [WERR_W-1:0] ERR_LIM  = WERR_W'(ERR_THR);

    function automatic logic [31:0] lfsr_step(input logic [31:0] q);
        return {q[30:0], q[31] ^ q[21] ^ q[1] ^ q[0]};
    endfunction

    state_t              r_state;
    logic [31:0]         r_s1;
    logic [31:0]         r_s2;
    logic [15:0]         r_div;
    logic [RUN_W-1:0]    r_run;
    logic [WIN_W-1:0]    r_win;
    logic [WERR_W-1:0]   r_win_err;
    logic [15:0]         r_err_cnt;
    logic                r_err;

    logic                w_consume;
    logic [31:0]         w_s1;
    logic [31:0]         w_s2;
    logic [15:0]         w_div;
    logic                w_div_wrap;
    logic                w_mismatch;
    logic [RUN_W-1:0]    w_run_base;
    logic [RUN_W-1:0]    w_run_nxt;
    logic [WERR_W-1:0]   w_werr_nxt;
    logic [15:0]         w_cnt_base;
    logic [15:0]         w_cnt_nxt;
    state_t              w_state_base;

    // A start bit is checked against the seeds directly, so the same cycle restarts the sequence.
    assign w_consume    = i_start | (i_din_valid & (r_state != ST_IDLE));
    assign w_s1         = i_start ? SEED1 : r_s1;
    assign w_s2         = i_start ? SEED2 : r_s2;
    assign w_div        = i_start ? 16'd0 : r_div;
    assign w_div_wrap   = (w_div == DIV_LAST);
    assign w_mismatch   = i_din ^ (^(w_s1 & w_s2));
    assign w_run_base   = i_start ? '0 : r_run;
    assign w_run_nxt    = w_mismatch ? '0 : w_run_base + RUN_W'(1);
    assign w_werr_nxt   = r_win_err + WERR_W'(w_mismatch);
    assign w_cnt_base   = i_start ? 16'd0 : r_err_cnt;
    assign w_cnt_nxt    = (w_mismatch && (w_cnt_base != 16'hFFFF)) ? w_cnt_base + 16'd1 : w_cnt_base;
    assign w_state_base = i_start ? ST_CHECK : r_state;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_s1      <= SEED1;
            r_s2      <= SEED2;
            r_div     <= 16'd0;
            r_run     <= '0;
            r_win     <= '0;
            r_win_err <= '0;
            r_err_cnt <= 16'd0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_consume & w_mismatch;
            if (w_consume) begin
                r_s2      <= lfsr_step(w_s2);
                r_s1      <= w_div_wrap ? lfsr_step(w_s1) : w_s1;
                r_div     <= w_div_wrap ? 16'd0 : w_div + 16'd1;
                r_err_cnt <= w_cnt_nxt;
                r_state   <= w_state_base;
                if (i_start) begin
                    r_win     <= '0;
                    r_win_err <= '0;
                end
                case (w_state_base)
                    ST_CHECK: begin
                        r_run <= w_run_nxt;
                        if (w_run_nxt == RUN_LOCK) r_state <= ST_LOCKED;
                    end
                    ST_LOCKED: begin
                        if (w_werr_nxt >= ERR_LIM) r_state <= ST_LOST;
                        if (r_win == WIN_LAST) begin
                            r_win     <= '0;
                            r_win_err <= '0;
                        end else begin
                            r_win     <= r_win + WIN_W'(1);
                            r_win_err <= w_werr_nxt;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_err     = r_err;
    assign o_locked  = (r_state == ST_LOCKED);
    assign o_lost    = (r_state == ST_LOST);
    assign o_err_cnt = r_err_cnt;
    assign o_state   = r_state;

endmodule

// File: tb/tb_msip_chk.sv
// Directed bench for msip_chk: a local generator model supplies the stream and
// each scenario task compares the checker outputs with hand-derived expectations.
module tb_msip_chk;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        err;
    logic        locked;
    logic        lost;
    logic [15:0] err_cnt;
    logic [1:0]  state;

    int          n_checks = 0;
    int          n_fail = 0;

    logic [31:0] g_s1;
    logic [31:0] g_s2;
    int          g_div;

    always #5 clk = ~clk;

    msip_chk dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (start),
        .i_din      (din),
        .i_din_valid(din_valid),
        .o_err      (err),
        .o_locked   (locked),
        .o_lost     (lost),
        .o_err_cnt  (err_cnt),
        .o_state    (state)
    );

    function automatic logic [31:0] gen_step(input logic [31:0] q);
        return {q[30:0], q[31] ^ q[21] ^ q[1] ^ q[0]};
    endfunction

    task automatic gen_reset();
        g_s1  = 32'hACE10001;
        g_s2  = 32'h12345678;
        g_div = 0;
    endtask

    task automatic gen_next(output logic b);
        b = ^(g_s1 & g_s2);
        g_s2 = gen_step(g_s2);
        if (g_div == 9) begin
            g_s1  = gen_step(g_s1);
            g_div = 0;
        end else begin
            g_div = g_div + 1;
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then settle past the rising edge.
    task automatic send(input logic st, input logic d, input logic v);
        @(negedge clk);
        start     = st;
        din       = d;
        din_valid = v;
        @(posedge clk);
        #1;
        start     = 1'b0;
    endtask

    task automatic send_bit(input logic flip);
        logic b;
        gen_next(b);
        send(1'b0, b ^ flip, 1'b1);
    endtask

    task automatic send_start_aligned();
        logic b;
        gen_reset();
        gen_next(b);
        send(1'b1, b, 1'b1);
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (err !== 1'b0)      begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        n_checks++; if (locked !== 1'b0)   begin n_fail++; $display("FAIL reset_locked got %b want 0", locked); end
        n_checks++; if (lost !== 1'b0)     begin n_fail++; $display("FAIL reset_lost got %b want 0", lost); end
        n_checks++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_err_cnt got %h want 0000", err_cnt); end
        n_checks++; if (state !== 2'b00)   begin n_fail++; $display("FAIL reset_state got %b want 00", state); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_start_mismatch();
        send(1'b1, 1'b0, 1'b1);
        n_checks++; if (err !== 1'b1)      begin n_fail++; $display("FAIL start_err got %b want 1", err); end
        n_checks++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL start_err_cnt got %h want 0001", err_cnt); end
        n_checks++; if (state !== 2'b01)   begin n_fail++; $display("FAIL start_state got %b want 01", state); end
        send(1'b0, 1'b0, 1'b0);
        n_checks++; if (err !== 1'b0)      begin n_fail++; $display("FAIL start_err_drop got %b want 0", err); end
    endtask

    task automatic test_lock();
        int pulses = 0;
        send_start_aligned();
        n_checks++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL lock_cnt_clear got %h want 0000", err_cnt); end
        for (int n = 2; n <= 64; n++) begin
            send_bit(1'b0);
            if (n == 63) begin
                n_checks++; if (locked !== 1'b0 || state !== 2'b01) begin n_fail++; $display("FAIL lock_early locked=%b state=%b want 0/01", locked, state); end
            end
        end
        n_checks++; if (locked !== 1'b1 || state !== 2'b10) begin n_fail++; $display("FAIL lock_at_64 locked=%b state=%b want 1/10", locked, state); end
        for (int n = 65; n <= 10000; n++) begin
            send_bit(1'b0);
            if (err) pulses++;
        end
        n_checks++; if (pulses !== 0)      begin n_fail++; $display("FAIL lock_pulses got %0d want 0", pulses); end
        n_checks++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL lock_err_cnt got %h want 0000", err_cnt); end
        n_checks++; if (locked !== 1'b1)   begin n_fail++; $display("FAIL lock_hold got %b want 1", locked); end
    endtask

    task automatic test_window();
        int drops = 0;
        int pulses = 0;
        logic flip;
        send_start_aligned();
        for (int n = 2; n <= 64; n++) send_bit(1'b0);
        // First locked window spans bits 65..320, the second 321..576.
        for (int n = 65; n <= 576; n++) begin
            flip = ((n >= 100 && n <= 106) || (n >= 400 && n <= 407));
            send_bit(flip);
            if (n == 100) begin
                n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL win_err_pulse got %b want 1", err); end
            end
            if (n == 320) begin
                n_checks++; if (state !== 2'b10)   begin n_fail++; $display("FAIL win7_state got %b want 10", state); end
                n_checks++; if (err_cnt !== 16'd7) begin n_fail++; $display("FAIL win7_err_cnt got %0d want 7", err_cnt); end
            end
            if (n == 406) begin
                n_checks++; if (state !== 2'b10) begin n_fail++; $display("FAIL win_pre_lost got %b want 10", state); end
            end
            if (n == 407) begin
                n_checks++; if (state !== 2'b11 || lost !== 1'b1 || locked !== 1'b0)
                    begin n_fail++; $display("FAIL win_lost state=%b lost=%b locked=%b want 11/1/0", state, lost, locked); end
            end
        end
        for (int n = 0; n < 1000; n++) begin
            send_bit(1'b0);
            if (!lost) drops++;
            if (err) pulses++;
        end
        n_checks++; if (drops !== 0)        begin n_fail++; $display("FAIL lost_sticky drops=%0d want 0", drops); end
        n_checks++; if (pulses !== 0)       begin n_fail++; $display("FAIL lost_clean pulses=%0d want 0", pulses); end
        n_checks++; if (err_cnt !== 16'd15) begin n_fail++; $display("FAIL lost_err_cnt got %0d want 15", err_cnt); end
    endtask

    task automatic test_valid_gaps();
        int nvalid = 1;
        send_start_aligned();
        while (nvalid < 264) begin
            if ($urandom_range(0, 1) == 1) begin
                send_bit(1'b0);
                nvalid++;
                if (nvalid == 63) begin
                    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL gap_early_lock got %b want 0", locked); end
                end
                if (nvalid == 64) begin
                    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL gap_lock got %b want 1", locked); end
                end
            end else begin
                send(1'b0, 1'($urandom_range(0, 1)), 1'b0);
                n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL gap_idle_err got %b want 0", err); end
            end
        end
        n_checks++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL gap_err_cnt got %h want 0000", err_cnt); end
        n_checks++; if (locked !== 1'b1)   begin n_fail++; $display("FAIL gap_hold got %b want 1", locked); end
    endtask

    task automatic test_misaligned();
        int ever_locked = 0;
        gen_reset();
        send(1'b1, 1'b0, 1'b1);
        for (int n = 2; n <= 2000; n++) begin
            send_bit(1'b0);
            if (locked) ever_locked++;
        end
        n_checks++; if (ever_locked !== 0) begin n_fail++; $display("FAIL mis_locked cycles=%0d want 0", ever_locked); end
        n_checks++; if (err_cnt < 16'd700 || err_cnt > 16'd1300)
            begin n_fail++; $display("FAIL mis_err_cnt got %0d want 700..1300", err_cnt); end
        send_start_aligned();
        n_checks++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL realign_clear got %0d want 0", err_cnt); end
        for (int n = 2; n <= 64; n++) send_bit(1'b0);
        n_checks++; if (locked !== 1'b1 || err_cnt !== 16'd0)
            begin n_fail++; $display("FAIL realign_lock locked=%b err_cnt=%0d want 1/0", locked, err_cnt); end
    endtask

    task automatic test_async_reset();
        int pulses = 0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({err, locked, lost} !== 3'b000 || err_cnt !== 16'd0 || state !== 2'b00)
            begin n_fail++; $display("FAIL async_rst err=%b locked=%b lost=%b cnt=%h state=%b want all 0", err, locked, lost, err_cnt, state); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send(1'b0, 1'(i & 1), 1'b1);
            if (err) pulses++;
        end
        n_checks++; if (pulses !== 0 || err_cnt !== 16'd0 || state !== 2'b00)
            begin n_fail++; $display("FAIL idle_ignore pulses=%0d cnt=%h state=%b want 0/0000/00", pulses, err_cnt, state); end
    endtask

    task automatic test_saturation();
        send_start_aligned();
        for (int n = 2; n <= 64; n++) send_bit(1'b0);
        @(negedge clk);
        din_valid = 1'b0;
        force dut.r_err_cnt = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.r_err_cnt;
        for (int k = 1; k <= 3; k++) begin
            send_bit(1'b1);
            n_checks++; if (err_cnt !== 16'hFFFF || err !== 1'b1)
                begin n_fail++; $display("FAIL sat_%0d err_cnt=%h err=%b want FFFF/1", k, err_cnt, err); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_start_mismatch();
        test_lock();
        test_window();
        test_valid_gaps();
        test_misaligned();
        test_async_reset();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
